wallace_mul_scheduler: RTL and testbench

Issue scheduler sharing one pipelined 32x32 Wallace tree multiplier between N_REQ requesters. Arbitrates round-robin, registers the winning operand pair into the multiplier, tracks each in-flight operation with a tag shift register matched to the multiplier latency, and buffers products in a result FIFO. The multiplier pipeline cannot stall, so issue is credit-gated to guarantee FIFO space for every product in flight.

---
 rtl/wallace_mul_pkg.sv | 13 +
 rtl/mul_result_fifo.sv | 36 +++
 rtl/wallace_mul_scheduler.sv | 86 ++++++++
 tb/tb_wallace_mul_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wallace_mul_pkg.sv
// wallace_mul_pkg: shared widths, result-entry type and clog2 helper for the multiplier scheduler
package wallace_mul_pkg;
  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;
  localparam int ID_MAX_W = 3;
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [PRODUCT_W-1:0] product;
  } res_entry_t;
  function automatic int clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: synchronous result FIFO with occupancy count; head reads zero when empty
module mul_result_fifo
  import wallace_mul_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 67
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wallace_mul_scheduler.sv
// wallace_mul_scheduler: round-robin, credit-gated issue into a shared pipelined multiplier with tagged result FIFO
module wallace_mul_scheduler
  import wallace_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MUL_LATENCY = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [OPERAND_W*N_REQ-1:0] req_a,
  input  logic [OPERAND_W*N_REQ-1:0] req_b,
  output logic [OPERAND_W-1:0] mul_a,
  output logic [OPERAND_W-1:0] mul_b,
  input  logic [PRODUCT_W-1:0] mul_p,
  output logic res_valid,
  input  logic res_ready,
  output logic [clog2(N_REQ)-1:0] res_id,
  output logic [PRODUCT_W-1:0] res_product,
  output logic busy
);
  localparam int IDW = clog2(N_REQ);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  logic [IDW-1:0] rr_ptr, win;
  logic [IDW:0] idx;
  logic found, room, issue, push;
  logic [CW-1:0] fifo_count, inflight;
  logic [MUL_LATENCY:0] tag_v;
  logic [IDW-1:0] tag_id [MUL_LATENCY+1];
  res_entry_t push_entry, head;
  always_comb begin
    found = 1'b0;
    win = rr_ptr;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      idx = idx >= (IDW+1)'(N_REQ) ? idx - (IDW+1)'(N_REQ) : idx;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win = idx[IDW-1:0];
      end
    end
  end
  assign room = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign issue = found && room && !sync_reset;
  assign req_ready = issue ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  // The tag is loaded alongside mul_a/mul_b, so it needs one stage beyond the multiplier latency to meet its product.
  assign push = tag_v[MUL_LATENCY];
  assign push_entry = '{id: ID_MAX_W'(tag_id[MUL_LATENCY]), product: mul_p};
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rr_ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
      tag_v <= '0;
      inflight <= '0;
    end else begin
      tag_v <= {tag_v[MUL_LATENCY-1:0], issue};
      inflight <= inflight + CW'(issue) - CW'(push);
      if (issue) begin
        mul_a <= req_a[OPERAND_W*win +: OPERAND_W];
        mul_b <= req_b[OPERAND_W*win +: OPERAND_W];
        rr_ptr <= win == IDW'(N_REQ-1) ? '0 : win + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    tag_id[0] <= win;
    for (int k = 1; k <= MUL_LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end
  mul_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(res_entry_t))) fifo (
    .clk(clk),
    .rst(sync_reset),
    .push(push),
    .pop(res_ready),
    .wdata(push_entry),
    .head(head),
    .count(fifo_count)
  );
  assign res_valid = fifo_count != '0;
  assign res_id = head.id[IDW-1:0];
  assign res_product = head.product;
  assign busy = inflight != '0 || fifo_count != '0;
endmodule

// File: tb/tb_wallace_mul_scheduler.sv
// tb_wallace_mul_scheduler: scoreboard model of grants, credit and result timing plus directed literal checks
module tb_wallace_mul_scheduler;
  localparam int N = 4, L = 8, D = 16;
  logic clk = 0, sync_reset = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p, res_product;
  logic res_valid, res_ready = 0, busy;
  logic [1:0] res_id;
  int vectors = 0, miscompares = 0, edges = 0, cnt;
  always #5 clk = ~clk;
  wallace_mul_scheduler #(.N_REQ(N), .MUL_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .sync_reset(sync_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_product(res_product), .busy(busy)
  );
  // external multiplier: L register stages after the operand registers
  logic [63:0] pp [L];
  always @(posedge clk) begin
    pp[0] <= 64'(mul_a) * 64'(mul_b);
    for (int k = 1; k < L; k++) pp[k] <= pp[k-1];
  end
  assign mul_p = pp[L-1];
  always @(posedge clk) edges <= edges + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  typedef struct { logic [1:0] id; logic [63:0] prod; int ready_at; } exp_t;
  exp_t q[$];
  int rr = 0;
  logic [31:0] ea = 0, eb = 0;
  // model: outstanding ops = issued minus consumed; result visible L+1 edges after its issue edge
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic ev;
    int w;
    er = '0;
    w = -1;
    if (!sync_reset && q.size() < D)
      for (int k = 0; k < N; k++) if (w < 0 && req_valid[(rr+k)%N]) w = (rr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (sync_reset) begin
      q.delete();
      rr = 0;
      ea = 0;
      eb = 0;
    end else begin
      ev = q.size() != 0 && q[0].ready_at <= edges;
      chk("res_valid", 64'(res_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("mul_a", 64'(mul_a), 64'(ea));
      chk("mul_b", 64'(mul_b), 64'(eb));
      if (ev) begin
        chk("res_id", 64'(res_id), 64'(q[0].id));
        chk("res_product", res_product, q[0].prod);
        if (res_ready) void'(q.pop_front());
      end else begin
        chk("empty head", res_product, 64'd0);
      end
      if (w >= 0) begin
        ea = req_a[32*w +: 32];
        eb = req_b[32*w +: 32];
        q.push_back('{2'(w), 64'(ea) * 64'(eb), edges + L + 2});
        rr = (w + 1) % N;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_result(input string name, input logic [1:0] id, input logic [63:0] p, input int lat);
    int n = 0;
    while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " id"}, 64'(res_id), 64'(id));
    chk({name, " product"}, res_product, p);
  endtask
  initial begin
    step(3);
    sync_reset = 0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst mul_a", 64'(mul_a), 64'd0);
    step(2);
    // single request from requester 2
    res_ready = 1;
    req_valid = 4'b0100;
    req_a[95:64] = 32'hFFFF_FFFF;
    req_b[95:64] = 32'hFFFF_FFFF;
    step(1);
    req_valid = '0;
    wait_result("single", 2'd2, 64'hFFFF_FFFE_0000_0001, L + 1);
    step(1);
    chk("single busy drop", 64'(busy), 64'd0);
    // all four streaming
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h1234_5678 + 32'(i * 32'h1111_1111);
      req_b[32*i +: 32] = 32'h0000_1000 * 32'(i + 3);
    end
    req_valid = 4'b1111;
    step(20);
    req_valid = '0;
    step(15);
    // back-pressure: exactly D issues
    res_ready = 0;
    req_valid = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      req_a[31:0] = 32'(i * 7 + 1);
      req_b[31:0] = 32'(i + 100);
      #1;
      if (req_ready[0]) cnt++;
      @(posedge clk); #1;
    end
    chk("bp issue count", 64'(cnt), 64'(D));
    chk("bp ready low", 64'(req_ready), 64'd0);
    res_ready = 1;
    step(10);
    req_valid = '0;
    step(30);
    chk("bp drained", 64'(busy), 64'd0);
    // full FIFO with res_ready toggling
    res_ready = 0;
    req_valid = 4'b0011;
    step(25);
    for (int i = 0; i < 24; i++) begin
      res_ready = ~res_ready;
      req_a[63:32] = 32'hA000_0000 + 32'(i);
      step(1);
    end
    req_valid = '0;
    res_ready = 1;
    step(30);
    // reset with 5 in flight and 3 buffered
    res_ready = 0;
    req_valid = 4'b1111;
    step(8);
    req_valid = '0;
    step(4);
    chk("pre-reset res_valid", 64'(res_valid), 64'd1);
    chk("pre-reset busy", 64'(busy), 64'd1);
    sync_reset = 1;
    step(1);
    sync_reset = 0;
    chk("post-reset res_valid", 64'(res_valid), 64'd0);
    chk("post-reset busy", 64'(busy), 64'd0);
    res_ready = 1;
    req_valid = 4'b1111;
    #1;
    chk("post-reset rr_ptr", 64'(req_ready), 64'd1);
    step(1);
    req_valid = '0;
    step(20);
    // zero operands, then 1 * 0x80000000
    req_valid = 4'b0010;
    req_a[63:32] = 32'd0;
    req_b[63:32] = 32'd0;
    step(1);
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'h8000_0000;
    step(1);
    req_valid = '0;
    wait_result("zero", 2'd1, 64'd0, L);
    step(1);
    wait_result("msb", 2'd1, 64'h0000_0000_8000_0000, 0);
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
